// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: latches a WIDTH-bit pattern on start and shifts it
// out MSB-first, repeated a programmable number of times with idle gaps between.
module seq_pattern_tx #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4,
    parameter int GAP_W = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    // Handshake: start is a request with no ready; it is taken only on an edge
    // where the block is IDLE (busy=0) and abort=0, otherwise it is dropped.
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] pattern_in,
    input  logic [CNT_W-1:0] repeat_cnt,
    input  logic [GAP_W-1:0] gap_len,
    output logic             data_out,
    output logic             data_valid,
    output logic             busy,
    output logic             done,
    output logic [1:0]       dbg_state_o
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic [CNT_W-1:0] reps_q, reps_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [GAP_W-1:0] gcnt_q, gcnt_d;
    logic             data_out_q, data_out_d;
    logic             data_valid_q, data_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        bit_idx_d = bit_idx_q;
        reps_d    = reps_q;
        gap_d     = gap_q;
        gcnt_d    = gcnt_q;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    pat_d     = pattern_in;
                    reps_d    = (repeat_cnt == '0) ? CNT_W'(1) : repeat_cnt;
                    gap_d     = gap_len;
                    bit_idx_d = LAST_IDX;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (bit_idx_q != '0) begin
                    bit_idx_d = bit_idx_q - 1'b1;
                end else if (reps_q > CNT_W'(1)) begin
                    reps_d    = reps_q - 1'b1;
                    bit_idx_d = LAST_IDX;
                    if (gap_q != '0) begin
                        gcnt_d  = gap_q;
                        state_d = ST_GAP;
                    end
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_GAP: begin
                // Counter holds the number of gap cycles still to spend, including this one.
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (gcnt_q <= GAP_W'(1)) begin
                    gcnt_d  = '0;
                    state_d = ST_SHIFT;
                end else begin
                    gcnt_d = gcnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next-state decode so they line up with state_q.
        data_valid_d = (state_d == ST_SHIFT);
        data_out_d   = (state_d == ST_SHIFT) ? pat_d[bit_idx_d] : 1'b0;
        busy_d       = (state_d != ST_IDLE);
        done_d       = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            pat_q        <= '0;
            bit_idx_q    <= '0;
            reps_q       <= '0;
            gap_q        <= '0;
            gcnt_q       <= '0;
            data_out_q   <= 1'b0;
            data_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pat_q        <= pat_d;
            bit_idx_q    <= bit_idx_d;
            reps_q       <= reps_d;
            gap_q        <= gap_d;
            gcnt_q       <= gcnt_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign data_out    = data_out_q;
    assign data_valid  = data_valid_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign dbg_state_o = state_q;

endmodule

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
Serial pattern transmitter: on a start request it latches a WIDTH-bit pattern and shifts it out MSB-first, one bit per clock, repeated a programmable number of times with a programmable idle gap between repetitions. It is the stimulus/transmit side of the serial bit-stream sequence detectors. data_out feeds a detector's data_in directly, and data_valid qualifies each bit.

Parameters:
WIDTH, 4, pattern length in bits (>=2)
CNT_W, 4, width of repeat_cnt and the internal repetition counter
GAP_W, 3, width of gap_len and the internal gap counter

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous, active-low reset
start  input  1  request to begin a transfer; sampled every cycle, accepted only in IDLE
abort  input  1  synchronous cancel of a transfer in progress
pattern_in  input  WIDTH  pattern to send, latched when start is accepted
repeat_cnt  input  CNT_W  number of pattern repetitions, latched at accept; 0 treated as 1
gap_len  input  GAP_W  idle cycles between repetitions, latched at accept; 0 means back-to-back
data_out  output  1  serial bit, registered
data_valid  output  1  high while data_out carries a pattern bit, registered
busy  output  1  high from the cycle after accept through the DONE cycle inclusive
done  output  1  one-cycle pulse after the last bit of the last repetition

Behaviour:
- Reset: asynchronous, active-low on reset_n; clock clk. On reset, state=IDLE; data_out, data_valid, busy, done=0; all counters and latches=0. Reset asserted mid-transfer kills it immediately, with no done pulse.
- All outputs are Moore/registered and decoded from state and shift register. No combinational input-to-output path.
- States: IDLE, SHIFT, GAP, DONE.
- IDLE:
  - start=1 and abort=0 at edge t0: latch pattern_in into the shift register, reps_left = max(repeat_cnt,1), gap_len; bit_idx=WIDTH-1; go to SHIFT.
  - abort=1 with start=1 in IDLE: start ignored.
- SHIFT (cycles t0+1 …):
  - data_valid=1, data_out=pattern[bit_idx]; bit_idx decrements each cycle.
  - After the bit at index 0: if reps_left>1, decrement reps_left and reload bit_idx=WIDTH-1. Then, if gap_len=0, stay in SHIFT (next pattern's MSB follows with no bubble); otherwise go to GAP with gap counter=gap_len.
  - If reps_left=1, go to DONE.
- GAP: data_out=0, data_valid=0, busy=1, for exactly gap_len cycles, then SHIFT.
- DONE: done=1, busy=1, data_valid=0, data_out=0 for one cycle, then IDLE.
- IDLE outputs: busy=0, data_valid=0, data_out=0, done=0.
- Latency: first bit is valid in cycle t0+1.
  - Total busy cycles = WIDTH*R + gap_len*(R-1) + 1, where R=max(repeat_cnt,1).
- start while not IDLE (including the DONE cycle): ignored, with no queueing. A new start is accepted in the first IDLE cycle after DONE.
- pattern_in, repeat_cnt, gap_len changes after accept: no effect on the transfer in progress.
- abort=1 in SHIFT, GAP or DONE: next state IDLE. Next cycle data_valid=0, busy=0, data_out=0, done=0 (a done already asserted in the same cycle completes normally).
- Counters never wrap: reps_left and gap counter saturate at their terminal values; bit_idx wraps only via explicit reload.

Test Plan:
- Reset: hold reset_n=0 with random inputs toggling -> data_out, data_valid, busy, done all 0; release -> IDLE, busy=0.
- Single send: pattern_in=4'b1101, repeat_cnt=1, gap_len=0, start pulse at t0 -> cycles t0+1..t0+4 data_out=1,1,0,1 with data_valid=1; done=1 at t0+5; busy=0 at t0+6. A detector fed from data_out flags the pattern.
- Repeat with gap: pattern 1101, repeat_cnt=3, gap_len=2 -> stream 1101 00 1101 00 1101 (data_valid low during the 0s), done at t0+17, busy high for 17 cycles. With gap_len=0 and repeat_cnt=2 -> 11011101 contiguous, done at t0+9.
- Ignore rules: start re-pulsed at t0+2 with pattern_in=4'b0000 changed -> output unchanged (1101); repeat_cnt=0 -> exactly one repetition.
- Abort: abort=1 during the 3rd SHIFT bit -> next cycle data_valid=0, busy=0, no done ever. start in the following cycle is accepted and the full pattern is sent. abort+start together in IDLE -> nothing sent.
- Async reset mid-transfer: reset_n dropped asynchronously in GAP -> outputs 0 immediately, no done. After release, a fresh start behaves as in the single-send scenario.
